code_conv_arbiter: RTL and testbench
====================================

# code_conv_arbiter

Shares a single binary/Gray code conversion datapath between two requesters. Each requester presents a WIDTH-bit word and a direction bit through a valid/ready handshake. A round-robin arbiter grants one request per cycle, and the converted word is captured in a one-entry output register tagged with the requester ID. The block sits between the requesting blocks and any downstream consumer that needs a registered, back-pressurable result stream.

## Interface
- WIDTH, 4, width of data words (WIDTH >= 2)
- clk  input  1  single clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- req0_valid  input  1  requester 0 has a word to convert
- req0_mode  input  1  requester 0 direction: 0 = binary->Gray, 1 = Gray->binary
- req0_data  input  WIDTH  requester 0 input word
- req0_ready  output  1  requester 0 word accepted this cycle (combinational)
- req1_valid  input  1  requester 1 has a word to convert
- req1_mode  input  1  requester 1 direction, same encoding as req0_mode
- req1_data  input  WIDTH  requester 1 input word
- req1_ready  output  1  requester 1 word accepted this cycle (combinational)
- out_valid  output  1  output register holds a result
- out_ready  input  1  downstream accepts the result this cycle
- out_id  output  1  requester that produced out_data
- out_data  output  WIDTH  converted word
- out_count  output  16  number of completed output handshakes; wraps modulo 2^16

## Operation
- Conversion, applied to the granted requester's data:
  - mode 0: out[i] = in[i] ^ in[i+1] for i < WIDTH-1; out[WIDTH-1] = in[WIDTH-1].
  - mode 1: out[i] = XOR of in[WIDTH-1:i], so out[WIDTH-1] = in[WIDTH-1].
- The output register can take a new word when space = !out_valid || out_ready.
- Arbitration state is last_grant (1 bit).
  - One requester valid: it is granted.
  - Both valid: the requester != last_grant is granted.
  - Neither valid: no grant.
- reqN_ready = granted_N && space. At most one ready is high in any cycle. A ready never depends on the requester's own valid beyond the grant decision.
- Accept = (req0_valid && req0_ready) || (req1_valid && req1_ready). On accept:
  - out_data is loaded with the converted word.
  - out_id is loaded with the granted index.
  - out_valid is set to 1.
  - last_grant is updated to the granted index.
- Output handshake fires when out_valid && out_ready.
  - No simultaneous accept: out_valid clears to 0.
  - Simultaneous accept: out_valid stays 1 and new contents are loaded (back-to-back throughput, one word per cycle).
- While out_valid && !out_ready:
  - out_data and out_id hold stable.
  - Both readys are 0.
  - last_grant is unchanged.
- out_count increments by 1 on every output handshake and wraps from 16'hFFFF to 0.
- Requesters must hold valid, mode and data stable until ready. The block does not buffer unaccepted requests.

## Timing
- Reset (rst high at a clock edge): out_valid = 0, out_id = 0, out_data = 0, out_count = 0, last_grant = 1. Requester 0 therefore wins the first contention.
- Reset takes priority over every other event, including a pending output or a simultaneous handshake. Any in-flight result is discarded.
- Readys are 0 in any cycle where rst is high.
- Latency: a word accepted at edge N appears on out_data with out_valid = 1 after edge N. Combinational input-to-output latency is zero paths: out_* are pure register outputs.
- Throughput: 1 word/cycle with out_ready held high. Under continuous contention, grants alternate 0,1,0,1 starting with 0 after reset.
- A stall on out_ready freezes arbitration. When the stall ends, the grant goes to the requester not served last.

## Test plan
- Reset, then req0 valid with mode 0, data 4'b1011, out_ready = 1 → req0_ready = 1; next cycle out_valid = 1, out_id = 0, out_data = 4'b1110; out_count = 1 after the handshake edge.
- req1 with mode 1, data 4'b1110 → out_id = 1, out_data = 4'b1011. Also sweep all 16 values in both modes through each port and check that binary->Gray->binary round-trips to identity.
- Both requesters valid continuously with out_ready = 1 for 6 cycles → grants 0,1,0,1,0,1; out_valid stays high; out_count advances by 1 per cycle.
- Hold out_ready = 0 for 3 cycles with both valid → out_data and out_id frozen, both readys 0. Release → pending word drains, the other requester is accepted in the same cycle, and out_valid stays 1.
- Assert rst while out_valid = 1 and out_ready = 0, with a request pending → next cycle all outputs 0. After reset, contention is granted to requester 0.
- Preload out_count to 16'hFFFE by streaming handshakes, then complete two more → out_count reads 16'hFFFF, then 16'h0000.

Source files
------------

// File: rtl/code_conv_arbiter.sv
// rtl/code_conv_arbiter.sv - two-requester round-robin binary/Gray converter with registered output
module code_conv_arbiter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic             req0_mode,
  input  logic [WIDTH-1:0] req0_data,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic             req1_mode,
  input  logic [WIDTH-1:0] req1_data,
  output logic             req1_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_id,
  output logic [WIDTH-1:0] out_data,
  output logic [15:0]      out_count
);

  logic             out_valid_q, out_valid_d;
  logic             out_id_q, out_id_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [15:0]      out_count_q, out_count_d;
  logic             last_grant_q, last_grant_d;

  logic             space;
  logic             grant0, grant1;
  logic             accept;
  logic             sel_mode;
  logic [WIDTH-1:0] sel_data;
  logic [WIDTH-1:0] conv_data;
  logic             acc;

  // Round-robin grant, ready generation and selection of the granted request
  always_comb begin
    space      = !out_valid_q || out_ready;
    grant0     = req0_valid && (!req1_valid || last_grant_q);
    grant1     = req1_valid && (!req0_valid || !last_grant_q);
    req0_ready = grant0 && space && !rst;
    req1_ready = grant1 && space && !rst;
    accept     = (req0_valid && req0_ready) || (req1_valid && req1_ready);
    sel_mode   = grant1 ? req1_mode : req0_mode;
    sel_data   = grant1 ? req1_data : req0_data;
  end

  // Shared conversion datapath: mode 0 binary->Gray, mode 1 Gray->binary (prefix XOR from MSB)
  always_comb begin
    conv_data = '0;
    acc       = 1'b0;
    if (!sel_mode) begin
      conv_data = sel_data ^ (sel_data >> 1);
    end else begin
      for (int i = WIDTH - 1; i >= 0; i--) begin
        acc          = acc ^ sel_data[i];
        conv_data[i] = acc;
      end
    end
  end

  // Output register next state: drain on handshake, reload on accept (accept wins for back-to-back)
  always_comb begin
    out_valid_d  = out_valid_q;
    out_id_d     = out_id_q;
    out_data_d   = out_data_q;
    out_count_d  = out_count_q;
    last_grant_d = last_grant_q;
    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
      out_count_d = out_count_q + 16'd1;
    end
    if (accept) begin
      out_valid_d  = 1'b1;
      out_data_d   = conv_data;
      out_id_d     = grant1;
      last_grant_d = grant1;
    end
  end

  // State registers; last_grant resets to 1 so requester 0 wins first contention
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      out_id_q     <= 1'b0;
      out_data_q   <= '0;
      out_count_q  <= 16'd0;
      last_grant_q <= 1'b1;
    end else begin
      out_valid_q  <= out_valid_d;
      out_id_q     <= out_id_d;
      out_data_q   <= out_data_d;
      out_count_q  <= out_count_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_id    = out_id_q;
  assign out_data  = out_data_q;
  assign out_count = out_count_q;

endmodule

// File: tb/tb_code_conv_arbiter.sv
// tb/tb_code_conv_arbiter.sv - directed self-checking bench for code_conv_arbiter
module tb_code_conv_arbiter;

  localparam int WIDTH = 4;

  logic             clk;
  logic             rst;
  logic             req0_valid, req0_mode, req0_ready;
  logic [WIDTH-1:0] req0_data;
  logic             req1_valid, req1_mode, req1_ready;
  logic [WIDTH-1:0] req1_data;
  logic             out_valid, out_ready, out_id;
  logic [WIDTH-1:0] out_data;
  logic [15:0]      out_count;

  int          n_checks = 0;
  int          n_pass   = 0;
  logic        pend;
  logic [15:0] exp_cnt;

  code_conv_arbiter #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_mode  (req0_mode),
    .req0_data  (req0_data),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_mode  (req1_mode),
    .req1_data  (req1_data),
    .req1_ready (req1_ready),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_id     (out_id),
    .out_data   (out_data),
    .out_count  (out_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  function automatic logic [WIDTH-1:0] to_gray(input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] g;
    g[WIDTH-1] = b[WIDTH-1];
    for (int i = 0; i < WIDTH - 1; i++) g[i] = b[i] ^ b[i+1];
    return g;
  endfunction

  function automatic logic [WIDTH-1:0] to_bin(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    b = g;
    for (int s = 1; s < WIDTH; s++) b = b ^ (g >> s);
    return b;
  endfunction

  // Advance one clock, modelling out_valid and the handshake counter
  task automatic tick(input logic acc);
    if (pend && out_ready) exp_cnt = exp_cnt + 16'd1;
    pend = acc || (pend && !out_ready);
    @(posedge clk);
    #1;
  endtask

  // Single-requester conversion through port p; returns observed output
  task automatic send(input int p, input logic m, input logic [WIDTH-1:0] d,
                      input logic [WIDTH-1:0] exp, output logic [WIDTH-1:0] got);
    if (p == 0) begin
      req0_valid = 1'b1; req0_mode = m; req0_data = d;
    end else begin
      req1_valid = 1'b1; req1_mode = m; req1_data = d;
    end
    #1;
    check("sweep_rdy0", {15'd0, req0_ready}, {15'd0, p == 0});
    check("sweep_rdy1", {15'd0, req1_ready}, {15'd0, p == 1});
    tick(1'b1);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    check("sweep_id", {15'd0, out_id}, p[15:0]);
    check("sweep_data", {12'd0, out_data}, {12'd0, exp});
    got = out_data;
  endtask

  initial begin
    logic [WIDTH-1:0] g, b;
    logic [WIDTH-1:0] gray3, gray5;
    int guard;
    rst = 1'b1; out_ready = 1'b0;
    req0_valid = 1'b1; req0_mode = 1'b0; req0_data = '0;
    req1_valid = 1'b0; req1_mode = 1'b0; req1_data = '0;
    pend = 1'b0; exp_cnt = 16'd0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("rst_rdy0", {15'd0, req0_ready}, 16'd0);
    req0_valid = 1'b0;
    rst = 1'b0;
    #1;
    check("rst_valid", {15'd0, out_valid}, 16'd0);
    check("rst_id", {15'd0, out_id}, 16'd0);
    check("rst_data", {12'd0, out_data}, 16'd0);
    check("rst_count", out_count, 16'd0);

    // Basic binary->Gray on port 0
    out_ready = 1'b1;
    req0_valid = 1'b1; req0_mode = 1'b0; req0_data = 4'b1011;
    #1;
    check("t1_rdy0", {15'd0, req0_ready}, 16'd1);
    check("t1_rdy1", {15'd0, req1_ready}, 16'd0);
    tick(1'b1);
    req0_valid = 1'b0;
    check("t1_valid", {15'd0, out_valid}, 16'd1);
    check("t1_id", {15'd0, out_id}, 16'd0);
    check("t1_data", {12'd0, out_data}, 16'b1110);
    tick(1'b0);
    check("t1_count", out_count, 16'd1);
    check("t1_drained", {15'd0, out_valid}, 16'd0);

    // Basic Gray->binary on port 1
    req1_valid = 1'b1; req1_mode = 1'b1; req1_data = 4'b1110;
    #1;
    check("t2_rdy1", {15'd0, req1_ready}, 16'd1);
    tick(1'b1);
    req1_valid = 1'b0;
    check("t2_id", {15'd0, out_id}, 16'd1);
    check("t2_data", {12'd0, out_data}, 16'b1011);

    // Sweep all values both modes through each port, plus round trip
    for (int p = 0; p < 2; p++) begin
      for (int v = 0; v < 16; v++) begin
        send(p, 1'b0, v[3:0], to_gray(v[3:0]), g);
        send(p, 1'b1, g, v[3:0], b);
        send(p, 1'b1, v[3:0], to_bin(v[3:0]), b);
      end
    end
    tick(1'b0);
    check("sweep_count", out_count, exp_cnt);

    // Continuous contention, last served was requester 1
    gray3 = 4'b0010;
    gray5 = 4'b0111;
    req0_valid = 1'b1; req0_mode = 1'b0; req0_data = 4'd3;
    req1_valid = 1'b1; req1_mode = 1'b0; req1_data = 4'd5;
    for (int k = 0; k < 6; k++) begin
      #1;
      check("rr_rdy0", {15'd0, req0_ready}, {15'd0, k % 2 == 0});
      check("rr_rdy1", {15'd0, req1_ready}, {15'd0, k % 2 == 1});
      tick(1'b1);
      check("rr_valid", {15'd0, out_valid}, 16'd1);
      check("rr_id", {15'd0, out_id}, (k % 2 == 0) ? 16'd0 : 16'd1);
      check("rr_data", {12'd0, out_data}, (k % 2 == 0) ? {12'd0, gray3} : {12'd0, gray5});
      check("rr_count", out_count, exp_cnt);
    end

    // Stall with both requesters valid
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("stall_rdy0", {15'd0, req0_ready}, 16'd0);
      check("stall_rdy1", {15'd0, req1_ready}, 16'd0);
      tick(1'b0);
      check("stall_id", {15'd0, out_id}, 16'd1);
      check("stall_data", {12'd0, out_data}, {12'd0, gray5});
      check("stall_valid", {15'd0, out_valid}, 16'd1);
    end
    out_ready = 1'b1;
    #1;
    check("release_rdy0", {15'd0, req0_ready}, 16'd1);
    check("release_rdy1", {15'd0, req1_ready}, 16'd0);
    tick(1'b1);
    check("release_valid", {15'd0, out_valid}, 16'd1);
    check("release_id", {15'd0, out_id}, 16'd0);
    check("release_data", {12'd0, out_data}, {12'd0, gray3});
    check("release_count", out_count, exp_cnt);

    // Reset while stalled with a request pending; last grant was 0
    out_ready = 1'b0;
    #1;
    rst = 1'b1;
    #1;
    check("rst2_rdy0", {15'd0, req0_ready}, 16'd0);
    check("rst2_rdy1", {15'd0, req1_ready}, 16'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    pend = 1'b0; exp_cnt = 16'd0;
    check("rst2_valid", {15'd0, out_valid}, 16'd0);
    check("rst2_id", {15'd0, out_id}, 16'd0);
    check("rst2_data", {12'd0, out_data}, 16'd0);
    check("rst2_count", out_count, 16'd0);
    out_ready = 1'b1;
    #1;
    check("rst2_win0", {15'd0, req0_ready}, 16'd1);
    check("rst2_lose1", {15'd0, req1_ready}, 16'd0);

    // Stream handshakes up to the counter wrap
    req1_valid = 1'b0;
    guard = 0;
    while (exp_cnt != 16'hFFFE && guard < 70000) begin
      tick(1'b1);
      guard++;
    end
    check("wrap_fffe", out_count, 16'hFFFE);
    tick(1'b1);
    check("wrap_ffff", out_count, 16'hFFFF);
    tick(1'b1);
    check("wrap_0000", out_count, 16'h0000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
